// File: rtl/window_pkg.sv
// Shared types and helpers for the 3x3 window generator.
// Pixels are packed RGB; coordinate widths come from coord_w().
package window_pkg;

    localparam int PIXEL_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Minimum of one bit so tiny dimensions still give a legal vector.
    function automatic int coord_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of storage: combinational read and synchronous write at the same address.
// A read in a write cycle returns the old contents, so data arrives with zero latency and is never stalled.
module line_buffer #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdat,
    output logic [WIDTH-1:0]  o_rdat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdat = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdat;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: one registered window 1 clk after each interior pixel, no backpressure.
// Optional WIN_POS_OUT_EN adds win_row/win_col reporting the window centre coordinate.
module window_3x3_gen
    import window_pkg::*;
#(
    parameter int  IMG_WIDTH  = 512,
    parameter int  IMG_HEIGHT = 512,
    localparam int COL_W      = coord_w(IMG_WIDTH),
    localparam int ROW_W      = coord_w(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    output logic [PIXEL_W-1:0] output_pixel_1,
    output logic [PIXEL_W-1:0] output_pixel_2,
    output logic [PIXEL_W-1:0] output_pixel_3,
    output logic [PIXEL_W-1:0] output_pixel_4,
    output logic [PIXEL_W-1:0] output_pixel_5,
    output logic [PIXEL_W-1:0] output_pixel_6,
    output logic [PIXEL_W-1:0] output_pixel_7,
    output logic [PIXEL_W-1:0] output_pixel_8,
    output logic [PIXEL_W-1:0] output_pixel_9,
`ifdef WIN_POS_OUT_EN
    output logic [ROW_W-1:0]   win_row,
    output logic [COL_W-1:0]   win_col,
`endif
    output logic               frame_done
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_frame_done;
    logic               r_out_valid;
    rgb_t               r_hist [3][2];
    rgb_t               r_win  [9];

    logic               w_col_last;
    logic               w_row_last;
    logic               w_win_vld;
    logic [PIXEL_W-1:0] w_lb0_rdat;
    logic [PIXEL_W-1:0] w_lb1_rdat;
    rgb_t               w_col [3];

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_win_vld  = in_valid && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // LB0 holds the previous line, LB1 the one before; LB1 is fed from LB0's pre-write data.
    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (PIXEL_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk    (clk),
        .i_en   (in_valid),
        .i_addr (r_col),
        .i_wdat (in_pixel),
        .o_rdat (w_lb0_rdat)
    );

    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (PIXEL_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk    (clk),
        .i_en   (in_valid),
        .i_addr (r_col),
        .i_wdat (w_lb0_rdat),
        .o_rdat (w_lb1_rdat)
    );

    assign w_col[0] = rgb_t'(w_lb1_rdat);
    assign w_col[1] = rgb_t'(w_lb0_rdat);
    assign w_col[2] = rgb_t'(in_pixel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= in_valid && w_col_last && w_row_last;
            if (in_valid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    // Column history: [k][0] is column c-1, [k][1] is column c-2 once the current beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                r_hist[k][0] <= '0;
                r_hist[k][1] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
                r_hist[k][0] <= w_col[k];
                r_hist[k][1] <= r_hist[k][0];
            end
        end
    end

    // The window is assembled from history plus the incoming column, so it lands one clk after the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_out_valid <= w_win_vld;
            if (w_win_vld) begin
                for (int k = 0; k < 3; k++) begin
                    r_win[3*k]   <= r_hist[k][1];
                    r_win[3*k+1] <= r_hist[k][0];
                    r_win[3*k+2] <= w_col[k];
                end
            end
        end
    end

`ifdef WIN_POS_OUT_EN
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_row <= '0;
            r_win_col <= '0;
        end else if (w_win_vld) begin
            r_win_row <= r_row - ROW_W'(1);
            r_win_col <= r_col - COL_W'(1);
        end
    end

    assign win_row = r_win_row;
    assign win_col = r_win_col;
`endif

    assign out_valid      = r_out_valid;
    assign frame_done     = r_frame_done;
    assign output_pixel_1 = r_win[0];
    assign output_pixel_2 = r_win[1];
    assign output_pixel_3 = r_win[2];
    assign output_pixel_4 = r_win[3];
    assign output_pixel_5 = r_win[4];
    assign output_pixel_6 = r_win[5];
    assign output_pixel_7 = r_win[6];
    assign output_pixel_8 = r_win[7];
    assign output_pixel_9 = r_win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on an 8x6 image: reference windows come straight from a stored image array.
module tb_window_3x3_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        out_valid;
    logic        frame_done;
    logic [23:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic [23:0] obs [9];
`ifdef WIN_POS_OUT_EN
    logic [2:0]  win_row;
    logic [2:0]  win_col;
    int          exp_wr;
    int          exp_wc;
`endif

    int          total = 0;
    int          bad = 0;
    logic [23:0] img [H][W];
    logic [23:0] exp_win [9];
    bit          e_vld = 1'b0;
    bit          e_fd = 1'b0;
    bit          armed = 1'b0;
    bit          pat_frame = 1'b0;
    int          m_r = 0;
    int          m_c = 0;
    int          win_cnt = 0;
    int          fd_cnt = 0;

    always #5 clk = ~clk;

    window_3x3_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_pixel       (in_pixel),
        .out_valid      (out_valid),
        .output_pixel_1 (p1),
        .output_pixel_2 (p2),
        .output_pixel_3 (p3),
        .output_pixel_4 (p4),
        .output_pixel_5 (p5),
        .output_pixel_6 (p6),
        .output_pixel_7 (p7),
        .output_pixel_8 (p8),
        .output_pixel_9 (p9),
`ifdef WIN_POS_OUT_EN
        .win_row        (win_row),
        .win_col        (win_col),
`endif
        .frame_done     (frame_done)
    );

    assign obs[0] = p1;
    assign obs[1] = p2;
    assign obs[2] = p3;
    assign obs[3] = p4;
    assign obs[4] = p5;
    assign obs[5] = p6;
    assign obs[6] = p7;
    assign obs[7] = p8;
    assign obs[8] = p9;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = {8'(r), 8'(c), 8'(r + c)};
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 24'($urandom);
    endtask

    // One clock: check what the previous edge produced, then drive the next inputs and predict.
    task automatic step(input bit v, input bit r, input logic [23:0] px);
        @(negedge clk);
        if (armed) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, e_vld});
            chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
            for (int k = 0; k < 9; k++)
                chk($sformatf("win_px%0d", k + 1), {8'd0, obs[k]}, {8'd0, exp_win[k]});
`ifdef WIN_POS_OUT_EN
            chk("win_row", {29'd0, win_row}, exp_wr);
            chk("win_col", {29'd0, win_col}, exp_wc);
`endif
            if (out_valid === 1'b1) begin
                if (pat_frame && win_cnt == 0) begin
                    chk("first_p1", {8'd0, p1}, 32'h000000);
                    chk("first_p5", {8'd0, p5}, 32'h010102);
                    chk("first_p9", {8'd0, p9}, 32'h020204);
                end
                win_cnt++;
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        armed    = 1'b1;
        rst      = r;
        in_valid = v;
        in_pixel = px;
        if (r) begin
            m_r = 0;
            m_c = 0;
            e_vld = 1'b0;
            e_fd = 1'b0;
            for (int k = 0; k < 9; k++) exp_win[k] = '0;
`ifdef WIN_POS_OUT_EN
            exp_wr = 0;
            exp_wc = 0;
`endif
        end else begin
            e_vld = v && (m_r >= 2) && (m_c >= 2);
            e_fd  = v && (m_r == H - 1) && (m_c == W - 1);
            if (e_vld) begin
                for (int k = 0; k < 9; k++)
                    exp_win[k] = img[m_r - 2 + k / 3][m_c - 2 + k % 3];
`ifdef WIN_POS_OUT_EN
                exp_wr = m_r - 1;
                exp_wc = m_c - 1;
`endif
            end
            if (v) begin
                if (m_c == W - 1) begin
                    m_c = 0;
                    m_r = (m_r == H - 1) ? 0 : m_r + 1;
                end else begin
                    m_c++;
                end
            end
        end
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                while ($urandom_range(0, 9) < 4) step(1'b0, 1'b0, 24'd0);
            step(1'b1, 1'b0, img[(i / W) % H][i % W]);
        end
    endtask

    initial begin
        for (int k = 0; k < 9; k++) exp_win[k] = '0;
`ifdef WIN_POS_OUT_EN
        exp_wr = 0;
        exp_wc = 0;
`endif
        step(1'b0, 1'b1, 24'd0);
        step(1'b0, 1'b1, 24'd0);
        step(1'b0, 1'b0, 24'd0);

        // Continuous pattern frame.
        fill_pattern();
        pat_frame = 1'b1;
        win_cnt = 0;
        fd_cnt = 0;
        feed(W * H, 1'b0);
        step(1'b0, 1'b0, 24'd0);
        chk("frame1_windows", win_cnt, 24);
        chk("frame1_done", fd_cnt, 1);

        // Same frame with idle gaps.
        win_cnt = 0;
        fd_cnt = 0;
        feed(W * H, 1'b1);
        step(1'b0, 1'b0, 24'd0);
        chk("gap_windows", win_cnt, 24);
        chk("gap_done", fd_cnt, 1);

        // Two back-to-back random-content frames.
        fill_random();
        pat_frame = 1'b0;
        win_cnt = 0;
        fd_cnt = 0;
        feed(W * H, 1'b0);
        feed(W * H, 1'b0);
        step(1'b0, 1'b0, 24'd0);
        chk("b2b_windows", win_cnt, 48);
        chk("b2b_done", fd_cnt, 2);

        // Reset while pixel (3,4) is presented, then a fresh gapped frame.
        fill_pattern();
        pat_frame = 1'b1;
        win_cnt = 0;
        feed(3 * W + 4, 1'b0);
        step(1'b1, 1'b1, img[3][4]);
        step(1'b0, 1'b1, 24'd0);
        step(1'b0, 1'b0, 24'd0);
        win_cnt = 0;
        fd_cnt = 0;
        feed(W * H, 1'b1);
        step(1'b0, 1'b0, 24'd0);
        chk("post_rst_windows", win_cnt, 24);
        chk("post_rst_done", fd_cnt, 1);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 24'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
